mac_tile_sequencer: RTL and testbench

- Cycle-level controller for one output tile of the 2-D MAC array, where each PE holds `channels_per_pe` input channels.
- Sequences four steps:
  - weight fetch from activation/weight SRAM (xmem) into the L0 buffer;
  - kernel load into the PEs;
  - activation streaming with execute;
  - partial-sum drain from the output FIFO (ofifo) into psum SRAM (pmem).
- Sits between the top-level testbench/host command interface and the core (xmem, L0, MAC array, ofifo, pmem).
- Issues the 2-bit array instruction and all memory strobes.

---
 rtl/mac_tile_sequencer_pkg.sv | 28 ++
 rtl/mac_tile_sequencer_xmem_fetch_pipe.sv | 73 +++++++
 rtl/mac_tile_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_mac_tile_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tile_sequencer_pkg.sv
// Shared types and constants for the MAC tile sequencer.
// No logic of its own; state encoding and array instruction codes live here.
// Default geometry matches an 8x8 PE array with 11-bit memory addressing.
package mac_tile_sequencer_pkg;

  // Sequencer phases, encoded 0..5 in tile order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WFETCH = 3'd1,
    KLOAD  = 3'd2,
    EXEC   = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Two-bit array instruction: bit1 execute, bit0 kernel load.
  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Default array geometry and field widths.
  localparam int ROW_DEF      = 8;
  localparam int COL_DEF      = 8;
  localparam int ADDR_W_DEF   = 11;
  localparam int CNT_W_DEF    = 11;
  localparam int LOAD_CYC_DEF = ROW_DEF + COL_DEF;

endpackage

// File: rtl/mac_tile_sequencer_xmem_fetch_pipe.sv
// xmem_fetch_pipe: issues xmem reads from base+k and writes the returned data into L0.
// Latency: cen/addr combinational from the registered index; l0_wr follows cen by one cycle.
// Backpressure: l0_full holds the index and suppresses cen; an in-flight l0_wr still lands.
module xmem_fetch_pipe
  import mac_tile_sequencer_pkg::*;
#(
  parameter int addr_w = ADDR_W_DEF,
  parameter int cnt_w  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [addr_w-1:0] base_i,
  input  logic [cnt_w-1:0]  total_i,
  input  logic              l0_full_i,
  input  logic              l0_rd_i,
  output logic              xmem_cen_o,
  output logic [addr_w-1:0] xmem_addr_o,
  output logic              l0_wr_o,
  output logic              fetch_done_o,
  output logic              l0_empty_o
);

  logic [cnt_w-1:0] k_q, k_d;
  logic [cnt_w-1:0] occ_q, occ_d;
  logic             wr_q, wr_d;
  logic             issue;

  // Decide whether a read goes out this cycle and advance the index / L0 occupancy.
  always_comb begin
    issue = en_i && !l0_full_i && (k_q != total_i);
    k_d   = k_q;
    occ_d = occ_q;
    wr_d  = issue;
    if (clear_i) begin
      k_d   = '0;
      occ_d = '0;
      wr_d  = 1'b0;
    end else begin
      if (issue) begin
        k_d = k_q + 1'b1;
      end
      // Occupancy is writes landed minus reads taken by the array.
      if (wr_q && !l0_rd_i) begin
        occ_d = occ_q + 1'b1;
      end else if (!wr_q && l0_rd_i) begin
        occ_d = occ_q - 1'b1;
      end
    end
  end

  // Index, delayed write strobe and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      k_q   <= '0;
      occ_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      k_q   <= k_d;
      occ_q <= occ_d;
      wr_q  <= wr_d;
    end
  end

  assign xmem_cen_o   = !issue;
  assign xmem_addr_o  = issue ? (base_i + addr_w'(k_q)) : '0;
  assign l0_wr_o      = wr_q;
  // Every read issued and its data written into L0.
  assign fetch_done_o = (k_q == total_i) && !wr_q;
  assign l0_empty_o   = (occ_q == '0);

endmodule

// File: rtl/mac_tile_sequencer.sv
// mac_tile_sequencer: weight fetch -> kernel load -> execute -> psum drain for one tile (option ZERO_SKIP_EN).
// Latency: roughly row + load_cyc + 2*num_x + a few cycles unstalled; strobes decode from registered state.
// Backpressure: l0_full stalls xmem issue in fetch/execute; ofifo_valid low stalls the drain.
module mac_tile_sequencer
  import mac_tile_sequencer_pkg::*;
#(
  parameter int row      = ROW_DEF,
  parameter int col      = COL_DEF,
  parameter int addr_w   = ADDR_W_DEF,
  parameter int cnt_w    = CNT_W_DEF,
  parameter int load_cyc = LOAD_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [addr_w-1:0] w_base_i,
  input  logic [addr_w-1:0] x_base_i,
  input  logic [addr_w-1:0] p_base_i,
  input  logic [cnt_w-1:0]  num_x_i,
  input  logic              w_row_zero_i,
  input  logic              l0_full_i,
  input  logic              ofifo_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        inst_w_o,
  output logic              xmem_cen_o,
  output logic [addr_w-1:0] xmem_addr_o,
  output logic              l0_wr_o,
  output logic              l0_rd_o,
  output logic              ofifo_rd_o,
  output logic              pmem_wen_o,
  output logic [addr_w-1:0] pmem_addr_o
`ifdef ZERO_SKIP_EN
  ,
  output logic              tile_skipped_o
`endif
);

  localparam int LC_W = $clog2(load_cyc + 1);
  // Column count only shapes the datapath, not the sequencing.
  localparam int unused_col = col;

  state_t            state_q, state_d;
  logic [LC_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [cnt_w-1:0]  m_q, m_d;
  logic [cnt_w-1:0]  num_x_q;
  logic [addr_w-1:0] w_base_q, x_base_q, p_base_q;
  logic              start_acc;

  logic              fetch_en, fetch_clear, fetch_rd;
  logic              fetch_done, fetch_empty;
  logic [addr_w-1:0] fetch_base;
  logic [cnt_w-1:0]  fetch_total;

  logic              skip_now;
  logic              skip_mode;

  assign start_acc = (state_q == IDLE) && start_i;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

`ifdef ZERO_SKIP_EN
  logic zero_and_q;
  logic skip_q;

  // AND the zero-row flag over every weight write; latch the skip decision until the next start.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      zero_and_q <= 1'b0;
      skip_q     <= 1'b0;
    end else if (start_acc) begin
      zero_and_q <= 1'b1;
      skip_q     <= 1'b0;
    end else begin
      if ((state_q == WFETCH) && l0_wr_o && !w_row_zero_i) begin
        zero_and_q <= 1'b0;
      end
      if ((state_q == WFETCH) && fetch_done && zero_and_q) begin
        skip_q <= 1'b1;
      end
    end
  end

  assign skip_now       = zero_and_q;
  assign skip_mode      = skip_q;
  assign tile_skipped_o = skip_q;
`else
  logic unused_w_row_zero;
  assign unused_w_row_zero = w_row_zero_i;
  assign skip_now          = 1'b0;
  assign skip_mode         = 1'b0;
`endif

  // Shared read pipeline: weights during WFETCH, activations during EXEC.
  xmem_fetch_pipe #(
    .addr_w (addr_w),
    .cnt_w  (cnt_w)
  ) u_fetch (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .clear_i      (fetch_clear),
    .en_i         (fetch_en),
    .base_i       (fetch_base),
    .total_i      (fetch_total),
    .l0_full_i    (l0_full_i),
    .l0_rd_i      (fetch_rd),
    .xmem_cen_o   (xmem_cen_o),
    .xmem_addr_o  (xmem_addr_o),
    .l0_wr_o      (l0_wr_o),
    .fetch_done_o (fetch_done),
    .l0_empty_o   (fetch_empty)
  );

  // State, phase counters and captured command fields.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
      m_q      <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      num_x_q  <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      m_q      <= m_d;
      if (start_acc) begin
        w_base_q <= w_base_i;
        x_base_q <= x_base_i;
        p_base_q <= p_base_i;
        num_x_q  <= num_x_i;
      end
    end
  end

  // Next-state and strobe decode for each phase.
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    m_d         = m_q;
    inst_w_o    = INST_NOP;
    l0_rd_o     = 1'b0;
    ofifo_rd_o  = 1'b0;
    pmem_wen_o  = 1'b1;
    pmem_addr_o = '0;
    fetch_en    = 1'b0;
    fetch_clear = 1'b0;
    fetch_rd    = 1'b0;
    fetch_base  = '0;
    fetch_total = '0;

    case (state_q)
      IDLE: begin
        fetch_clear = 1'b1;
        if (start_i) begin
          state_d = WFETCH;
        end
      end

      WFETCH: begin
        fetch_en    = 1'b1;
        fetch_base  = w_base_q;
        fetch_total = cnt_w'(row);
        if (fetch_done) begin
          state_d = skip_now ? DRAIN : KLOAD;
        end
      end

      KLOAD: begin
        // Reset the fetch index/occupancy so EXEC starts from x_base.
        fetch_clear = 1'b1;
        inst_w_o    = INST_LOAD;
        l0_rd_o     = 1'b1;
        if (ld_cnt_q == LC_W'(load_cyc - 1)) begin
          ld_cnt_d = '0;
          state_d  = (num_x_q == '0) ? DONE : EXEC;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end

      EXEC: begin
        fetch_en    = 1'b1;
        fetch_base  = x_base_q;
        fetch_total = num_x_q;
        if (!fetch_empty) begin
          inst_w_o = INST_EXEC;
          l0_rd_o  = 1'b1;
          fetch_rd = 1'b1;
        end
        if (fetch_done && fetch_empty) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (m_q == num_x_q) begin
          m_d     = '0;
          state_d = DONE;
        end else if (skip_mode) begin
          // Skipped tile: write zero rows without touching the ofifo.
          pmem_wen_o  = 1'b0;
          pmem_addr_o = p_base_q + addr_w'(m_q);
          m_d         = m_q + 1'b1;
        end else if (ofifo_valid_i) begin
          ofifo_rd_o  = 1'b1;
          pmem_wen_o  = 1'b0;
          pmem_addr_o = p_base_q + addr_w'(m_q);
          m_d         = m_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Self-checking bench for mac_tile_sequencer: directed and randomized tiles
// compared against an address/count model derived from the tile rules.
module tb_mac_tile_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, w_row_zero, l0_full, ofifo_valid;
  logic [10:0] w_base, x_base, p_base, num_x;
  logic        busy, done, xmem_cen, l0_wr, l0_rd, ofifo_rd, pmem_wen;
  logic [1:0]  inst_w;
  logic [10:0] xmem_addr, pmem_addr;
`ifdef ZERO_SKIP_EN
  logic        tile_skipped;
`endif

  mac_tile_sequencer dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .start_i       (start),
    .w_base_i      (w_base),
    .x_base_i      (x_base),
    .p_base_i      (p_base),
    .num_x_i       (num_x),
    .w_row_zero_i  (w_row_zero),
    .l0_full_i     (l0_full),
    .ofifo_valid_i (ofifo_valid),
    .busy_o        (busy),
    .done_o        (done),
    .inst_w_o      (inst_w),
    .xmem_cen_o    (xmem_cen),
    .xmem_addr_o   (xmem_addr),
    .l0_wr_o       (l0_wr),
    .l0_rd_o       (l0_rd),
    .ofifo_rd_o    (ofifo_rd),
    .pmem_wen_o    (pmem_wen),
    .pmem_addr_o   (pmem_addr)
`ifdef ZERO_SKIP_EN
    ,
    .tile_skipped_o (tile_skipped)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Observed activity for the current tile (sampled on negedge).
  int          n_rd, n_wr, n_ld, ld_runs, n_ex, n_pop, n_nov, n_badpop;
  int          n_pipe_bad, n_full_bad, n_rdbad, n_done;
  logic        ld_seen, prev_issue;
  logic [1:0]  prev_inst;
  logic [10:0] got_x[$];
  logic        got_ld[$];
  logic [10:0] got_p[$];
  int          got_pex[$];

  // Stimulus knobs for the per-cycle driver.
  int         stim_mode = 0;
  int         stall_cnt = 0;
  int         drain_idx = 0;
  int         nx_cur = 0;
  logic [3:0] vpat = 4'b1001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_ld = 0; ld_runs = 0; n_ex = 0; n_pop = 0; n_nov = 0;
    n_badpop = 0; n_pipe_bad = 0; n_full_bad = 0; n_rdbad = 0; n_done = 0;
    ld_seen = 1'b0;
    got_x.delete(); got_ld.delete(); got_p.delete(); got_pex.delete();
  endtask

  // Monitor: record every strobe and protocol violation.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_issue = 1'b0;
      prev_inst  = 2'b00;
    end else begin
      if (xmem_cen === 1'b0) begin
        n_rd++;
        got_x.push_back(xmem_addr);
        got_ld.push_back(ld_seen);
        if (l0_full) n_full_bad++;
      end
      if (l0_wr !== prev_issue) n_pipe_bad++;
      if (l0_wr === 1'b1) n_wr++;
      if (inst_w === 2'b01) begin
        n_ld++;
        ld_seen = 1'b1;
        if (prev_inst !== 2'b01) ld_runs++;
      end
      if (inst_w === 2'b10) n_ex++;
      if (l0_rd !== (inst_w != 2'b00)) n_rdbad++;
      if (pmem_wen === 1'b0) begin
        got_p.push_back(pmem_addr);
        got_pex.push_back(n_ex);
        if (!ofifo_valid) n_nov++;
      end
      if (ofifo_rd === 1'b1) begin
        n_pop++;
        if (!ofifo_valid || pmem_wen !== 1'b0) n_badpop++;
      end
      if (done === 1'b1) n_done++;
      prev_issue = (xmem_cen === 1'b0);
      prev_inst  = inst_w;
    end
  end

  // Driver: l0_full / ofifo_valid / w_row_zero per cycle according to stim_mode.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      l0_full     = 1'b0;
      ofifo_valid = 1'b1;
      w_row_zero  = 1'b0;
      case (stim_mode)
        1: begin
          l0_full     = ($urandom_range(3) == 0);
          ofifo_valid = ($urandom_range(1) == 1);
        end
        2: begin
          if (n_rd == 3 && stall_cnt < 3) begin
            l0_full = 1'b1;
            stall_cnt++;
          end
          if (n_ex == nx_cur && n_rd == 8 + nx_cur) begin
            ofifo_valid = vpat[drain_idx % 4];
            drain_idx++;
          end
        end
        3: begin
          ofifo_valid = 1'b0;
          w_row_zero  = 1'b1;
        end
        4: w_row_zero = (n_wr != 5);
        default: ;
      endcase
    end
  end

  task automatic start_tile(input logic [10:0] wb, xb, pb, input int nx, input int mode);
    clear_mon();
    stall_cnt = 0;
    drain_idx = 0;
    nx_cur    = nx;
    stim_mode = mode;
    @(posedge clk); #1;
    start = 1'b1; w_base = wb; x_base = xb; p_base = pb; num_x = 11'(nx);
    @(posedge clk); #1;
    start = 1'b0;
    w_base = 11'($urandom); x_base = 11'($urandom); p_base = 11'($urandom);
    num_x = 11'($urandom);
  endtask

  task automatic run_tile(input string tag, input logic [10:0] wb, xb, pb,
                          input int nx, input int mode, input bit exp_skip);
    int cyc;
    int nrd_exp;
    logic [10:0] ea;
    start_tile(wb, xb, pb, nx, mode);
    cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      // A start while busy must be ignored.
      start = (cyc == 5);
    end
    start = 1'b0;
    check({tag, "/no_timeout"}, 32'(cyc < 3000), 1);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "/busy_after"}, 32'(busy), 0);
    check({tag, "/done_pulses"}, 32'(n_done), 1);

    nrd_exp = exp_skip ? 8 : 8 + nx;
    check({tag, "/xmem_reads"}, 32'(n_rd), 32'(nrd_exp));
    check({tag, "/l0_writes"}, 32'(n_wr), 32'(nrd_exp));
    for (int i = 0; i < nrd_exp && i < got_x.size(); i++) begin
      if (i < 8) ea = 11'((int'(wb) + i) % 2048);
      else       ea = 11'((int'(xb) + i - 8) % 2048);
      check($sformatf("%s/xaddr%0d", tag, i), 32'(got_x[i]), 32'(ea));
      check($sformatf("%s/xphase%0d", tag, i), 32'(got_ld[i]), 32'(i >= 8));
    end
    check({tag, "/load_cycles"}, 32'(n_ld), exp_skip ? 0 : 16);
    check({tag, "/load_runs"}, 32'(ld_runs), exp_skip ? 0 : 1);
    check({tag, "/exec_cycles"}, 32'(n_ex), exp_skip ? 0 : 32'(nx));
    check({tag, "/pmem_writes"}, 32'(got_p.size()), 32'(nx));
    for (int i = 0; i < nx && i < got_p.size(); i++) begin
      check($sformatf("%s/paddr%0d", tag, i), 32'(got_p[i]), 32'((int'(pb) + i) % 2048));
      check($sformatf("%s/pafter%0d", tag, i), 32'(got_pex[i]), exp_skip ? 0 : 32'(nx));
    end
    check({tag, "/ofifo_pops"}, 32'(n_pop), exp_skip ? 0 : 32'(nx));
    check({tag, "/wen_without_valid"}, 32'(n_nov), exp_skip ? 32'(nx) : 0);
    check({tag, "/bad_pops"}, 32'(n_badpop), 0);
    check({tag, "/l0wr_align"}, 32'(n_pipe_bad), 0);
    check({tag, "/cen_while_full"}, 32'(n_full_bad), 0);
    check({tag, "/l0rd_vs_inst"}, 32'(n_rdbad), 0);
`ifdef ZERO_SKIP_EN
    check({tag, "/tile_skipped"}, 32'(tile_skipped), 32'(exp_skip));
`endif
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; start = 1'b0; w_row_zero = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0;
    w_base = '0; x_base = '0; p_base = '0; num_x = '0;
    clear_mon();
    prev_issue = 1'b0;
    prev_inst  = 2'b00;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset/busy", 32'(busy), 0);
    check("reset/done", 32'(done), 0);
    check("reset/inst_w", 32'(inst_w), 0);
    check("reset/xmem_cen", 32'(xmem_cen), 1);
    check("reset/xmem_addr", 32'(xmem_addr), 0);
    check("reset/l0_wr", 32'(l0_wr), 0);
    check("reset/l0_rd", 32'(l0_rd), 0);
    check("reset/ofifo_rd", 32'(ofifo_rd), 0);
    check("reset/pmem_wen", 32'(pmem_wen), 1);
    check("reset/pmem_addr", 32'(pmem_addr), 0);
    reset_n = 1'b1;

    // Directed tiles.
    run_tile("basic", 11'd0, 11'd16, 11'd0, 4, 0, 1'b0);
    run_tile("l0_stall", 11'd0, 11'd16, 11'd0, 4, 2, 1'b0);
    run_tile("nx0", 11'd100, 11'd200, 11'd300, 0, 0, 1'b0);
    run_tile("wrap", 11'd2044, 11'd2045, 11'd2046, 4, 0, 1'b0);

    // Reset in the middle of EXEC.
    start_tile(11'd8, 11'd40, 11'd60, 6, 0);
    cyc = 0;
    while (n_ex == 0 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst/reach_exec", 32'(n_ex > 0), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst/busy", 32'(busy), 0);
    check("rst/xmem_cen", 32'(xmem_cen), 1);
    check("rst/inst_w", 32'(inst_w), 0);
    check("rst/l0_wr", 32'(l0_wr), 0);
    check("rst/pmem_wen", 32'(pmem_wen), 1);
    clear_mon();
    repeat (6) @(posedge clk);
    #1;
    check("rst/quiet_reads", 32'(n_rd), 0);
    check("rst/quiet_writes", 32'(n_wr + got_p.size()), 0);
    check("rst/quiet_inst", 32'(n_ld + n_ex), 0);
    run_tile("post_reset", 11'd8, 11'd40, 11'd60, 5, 0, 1'b0);

    // Randomized tiles with random stalls and bases.
    for (int t = 0; t < 6; t++) begin
      run_tile($sformatf("rand%0d", t), 11'($urandom), 11'($urandom), 11'($urandom),
               int'($urandom_range(6)), 1, 1'b0);
    end

`ifdef ZERO_SKIP_EN
    run_tile("skip", 11'd5, 11'd50, 11'd2046, 3, 3, 1'b1);
    run_tile("skip_miss", 11'd5, 11'd50, 11'd10, 3, 4, 1'b0);
`endif

    stim_mode = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
